rf_wb_queue: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/wbq_match.sv | 43 ++++
 rtl/rf_wb_queue.sv | 125 ++++++++++++
 tb/tb_rf_wb_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types for register-file writeback logic: address/data widths,
// the hardwired-zero register index and the writeback request record.
package cpu_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wbq_match.sv
// Youngest-match search over the occupied part of the writeback queue.
// Returns the newest pending data for a register; register 0 never hits.
module wbq_match
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  wb_req_t [DEPTH-1:0] entries,
  input  logic [PW-1:0]       head,
  input  logic [PW:0]         count,
  input  logic [REG_AW-1:0]   lk_addr,
  output logic                hit,
  output logic [REG_DW-1:0]   data
);

  logic [DEPTH-1:0]             match_by_age;
  logic [DEPTH-1:0][REG_DW-1:0] data_by_age;

  // Re-index storage by age: offset 0 is the head (oldest), offset count-1 the tail side.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PW-1:0] idx;

    assign idx               = head + PW'(gi);
    assign match_by_age[gi]  = (count > (PW+1)'(gi)) && (entries[idx].addr == lk_addr);
    assign data_by_age[gi]   = entries[idx].data;
  end

  // Later (younger) matches override earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (lk_addr != REG_ZERO) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (match_by_age[i]) begin
          hit  = 1'b1;
          data = data_by_age[i];
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback queue feeding the register file's single write port, with two
// forwarding lookups. Optional counters are enabled by defining WBQ_STATS_EN.
module rf_wb_queue
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = REG_AW,
  parameter  int DW    = REG_DW,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          drain_en,
  output logic          rf_wr,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_data,
  input  logic [AW-1:0] lk1_addr,
  output logic          lk1_hit,
  output logic [DW-1:0] lk1_data,
  input  logic [AW-1:0] lk2_addr,
  output logic          lk2_hit,
  output logic [DW-1:0] lk2_data,
  output logic          empty
`ifdef WBQ_STATS_EN
  ,
  output logic [31:0]   stat_pushes,
  output logic [15:0]   stat_zero_drops,
  output logic [PW:0]   stat_hiwater
`endif
);

  // AW/DW must equal the cpu_pkg widths, since entries are stored as wb_req_t.
  wb_req_t [DEPTH-1:0] mem_reg;
  logic [PW-1:0]       head_reg;
  logic [PW-1:0]       tail_reg;
  logic [PW:0]         count_reg;
  logic [PW:0]         count_next;

  logic push;
  logic enq;
  logic pop;

  assign empty    = (count_reg == '0);
  assign in_ready = (count_reg != (PW+1)'(DEPTH));

  assign push = in_valid && in_ready;
  // Writes to register 0 are acknowledged but dropped so $0 stays zero.
  assign enq  = push && (in_addr != REG_ZERO);

  assign rf_wr   = !empty && drain_en;
  assign pop     = rf_wr;
  assign rf_addr = empty ? '0 : mem_reg[head_reg].addr;
  assign rf_data = empty ? '0 : mem_reg[head_reg].data;

  always_comb begin
    count_next = count_reg;
    case ({enq, pop})
      2'b10:   count_next = count_reg + (PW+1)'(1);
      2'b01:   count_next = count_reg - (PW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_reg   <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (pop) begin
        head_reg <= head_reg + PW'(1);
      end
      if (enq) begin
        mem_reg[tail_reg] <= wb_req_t'{addr: in_addr, data: in_data};
        tail_reg          <= tail_reg + PW'(1);
      end
    end
  end

  wbq_match #(.DEPTH(DEPTH)) u_match_lk1 (
    .entries (mem_reg),
    .head    (head_reg),
    .count   (count_reg),
    .lk_addr (lk1_addr),
    .hit     (lk1_hit),
    .data    (lk1_data)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match_lk2 (
    .entries (mem_reg),
    .head    (head_reg),
    .count   (count_reg),
    .lk_addr (lk2_addr),
    .hit     (lk2_hit),
    .data    (lk2_data)
  );

`ifdef WBQ_STATS_EN
  // Counters saturate instead of wrapping so long runs stay meaningful.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_pushes     <= '0;
      stat_zero_drops <= '0;
      stat_hiwater    <= '0;
    end else begin
      if (enq && (stat_pushes != '1)) begin
        stat_pushes <= stat_pushes + 32'd1;
      end
      if (push && (in_addr == REG_ZERO) && (stat_zero_drops != '1)) begin
        stat_zero_drops <= stat_zero_drops + 16'd1;
      end
      if (count_next > stat_hiwater) begin
        stat_hiwater <= count_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_rf_wb_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        drain_en = 1'b0;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  lk1_addr = '0;
  logic        lk1_hit;
  logic [31:0] lk1_data;
  logic [4:0]  lk2_addr = '0;
  logic        lk2_hit;
  logic [31:0] lk2_data;
  logic        empty;

  always #5 clk = ~clk;

  rf_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .drain_en (drain_en),
    .rf_wr    (rf_wr),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .lk1_addr (lk1_addr),
    .lk1_hit  (lk1_hit),
    .lk1_data (lk1_data),
    .lk2_addr (lk2_addr),
    .lk2_hit  (lk2_hit),
    .lk2_data (lk2_data),
    .empty    (empty)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic accepted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Newest pending value for a register; register 0 is never pending.
  function automatic void lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].addr == a) begin
          h = 1'b1;
          d = q[i].data;
          break;
        end
      end
    end
  endfunction

  // Check all outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic        h;
    logic [31:0] d;
    logic        exp_ready;
    logic        exp_wr;
    @(negedge clk);
    exp_ready = (q.size() != DEPTH);
    exp_wr    = (q.size() != 0) && drain_en;
    check("in_ready", in_ready, exp_ready);
    check("empty", empty, q.size() == 0);
    check("rf_wr", rf_wr, exp_wr);
    check("rf_addr", rf_addr, (q.size() != 0) ? q[0].addr : 5'd0);
    check("rf_data", rf_data, (q.size() != 0) ? q[0].data : 32'd0);
    lookup(lk1_addr, h, d);
    check("lk1_hit", lk1_hit, h);
    check("lk1_data", lk1_data, d);
    lookup(lk2_addr, h, d);
    check("lk2_hit", lk2_hit, h);
    check("lk2_data", lk2_data, d);
    accepted = in_valid && exp_ready && reset;
    @(posedge clk);
    if (reset) begin
      if (exp_wr) begin
        $display("commit r%0d <= 0x%08h", q[0].addr, q[0].data);
        void'(q.pop_front());
      end
      if (accepted && in_addr != 5'd0) q.push_back('{in_addr, in_data});
    end else begin
      q.delete();
    end
    #1;
  endtask

  task automatic push_wait(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    accepted = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) cycle();
    if (!accepted) check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    cycle();
    cycle();
    reset = 1'b1;

    // Single write, one-cycle latency to the file
    drain_en = 1'b1;
    push_wait(5'd5, 32'hDEADBEEF);
    check("lat_rf_wr", rf_wr, 1'b1);
    repeat (2) cycle();

    // Fill with drain held, hold a fifth request, then drain in order
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push_wait(5'(i), 32'(i * 17));
    check("full_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_addr  = 5'd9;
    in_data  = 32'h55;
    repeat (2) cycle();
    drain_en = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 10 && !accepted; n++) cycle();
    if (!accepted) check("fifth_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    repeat (6) cycle();

    // Forwarding of the youngest duplicate
    drain_en = 1'b0;
    lk1_addr = 5'd7;
    lk2_addr = 5'd3;
    push_wait(5'd7, 32'hA);
    push_wait(5'd7, 32'hB);
    cycle();
    drain_en = 1'b1;
    cycle();
    drain_en = 1'b0;
    cycle();
    drain_en = 1'b1;
    repeat (2) cycle();

    // Register 0 writes are dropped
    lk1_addr = 5'd0;
    push_wait(5'd0, 32'hFFFFFFFF);
    repeat (2) cycle();

    // Continuous push and drain across several pointer wraps
    push_wait(5'd1, 32'd100);
    in_valid = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      in_addr  = 5'(2 + i % 30);
      in_data  = 32'd101 + 32'(i);
      lk2_addr = in_addr;
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();

    // Asynchronous reset with entries pending
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) push_wait(5'(20 + i), 32'hC0 + 32'(i));
    #2 reset = 1'b0;
    #1;
    check("arst_empty", empty, 1'b1);
    check("arst_rf_wr", rf_wr, 1'b0);
    check("arst_ready", in_ready, 1'b1);
    q.delete();
    cycle();
    reset    = 1'b1;
    drain_en = 1'b1;
    repeat (4) cycle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr  = 5'($urandom_range(0, 7));
      in_data  = $urandom;
      drain_en = ($urandom_range(0, 1) != 0);
      lk1_addr = 5'($urandom_range(0, 7));
      lk2_addr = 5'($urandom_range(0, 7));
      cycle();
    end
    in_valid = 1'b0;
    drain_en = 1'b1;
    repeat (DEPTH + 2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
